multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal values are 8 to 64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1: width of the multiply iteration counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to execute one operation.
REQ-006 SHALL have port aluCtr, input, 4 bits: operation code, sampled when start is accepted.
REQ-007 SHALL have ports input1 and input2, input, WIDTH bits each: operands, sampled when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiply is iterating.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse that marks aluRes, zero and err as updated.
REQ-010 SHALL have port aluRes, output, WIDTH bits: registered result.
REQ-011 SHALL have port zero, output, 1 bit: registered flag, set when aluRes equals 0.
REQ-012 SHALL have port err, output, 1 bit: registered flag, set for an illegal aluCtr.

Function
REQ-013 SHALL support these opcodes:
  - 0000: AND.
  - 0001: OR.
  - 0010: ADD, modulo 2^WIDTH.
  - 0110: SUB, modulo 2^WIDTH.
  - 0111: SLT, unsigned; result is 1 if input1 < input2, else 0.
  - 1100: NOT, giving ~input1.
  - 1000: SLL, input1 << input2[CNT_W-2:0].
  - 1001: SRL, logical shift right by the same amount.
  - 1010: SRA, arithmetic shift right by the same amount.
  - 1101: MUL, low WIDTH bits of input1*input2, unsigned.
REQ-014 SHALL accept start only when busy=0.
REQ-015 SHALL ignore start while busy=1; the operands and opcode presented in that cycle are not captured.
REQ-016 SHALL, for every opcode except MUL, register the result at the accepting edge: done=1 in the next cycle, latency 1.
REQ-017 SHALL use a three-state FSM with states IDLE, MUL and FIN.
REQ-018 SHALL make these FSM transitions:
  - IDLE to MUL on an accepted MUL.
  - MUL to FIN after WIDTH shift-add iterations, one per clock.
  - FIN to IDLE, or FIN to MUL on a back-to-back accepted MUL.
REQ-019 SHALL, for MUL, latch operands at the accepting edge, iterate on the next WIDTH edges, then assert done; latency is WIDTH+1 edges.
REQ-020 SHALL drive busy=1 exactly while the FSM is in MUL.
REQ-021 SHALL pulse done for exactly one cycle per accepted operation.
REQ-022 SHALL accept start in the cycle in which done=1, giving back-to-back operation.
REQ-023 SHALL update zero for every legal opcode, including SLT and the shifts.
REQ-024 SHALL, for an illegal opcode, complete with latency 1 and register aluRes=0, zero=1, err=1.
REQ-025 SHALL clear err on the next legal operation.
REQ-026 SHALL hold aluRes, zero and err stable between done pulses.
REQ-027 SHALL treat a shift amount >= WIDTH as follows: SLL/SRL give 0; SRA gives all bits equal to input1[WIDTH-1].
REQ-028 SHALL not leave any output undriven or latched; all outputs are flops.

Reset
REQ-029 SHALL, on rst_n=0, immediately set state=IDLE, busy=0, done=0, aluRes=0, zero=0, err=0, and clear the iteration counter.
REQ-030 SHALL abort an in-flight MUL on reset, without producing a done pulse.
REQ-031 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the opcode localparams (OP_AND ... OP_MUL) and the FSM state encoding in a shared package, alu_pkg.
REQ-033 SHALL implement the iterative multiplier as one sub-module, alu_mul_iter, with its own start/done interface; the single-cycle datapath stays in the top level.

Verification
REQ-034 SHALL cover SUB with input1=5, input2=5 -> one cycle later done=1, aluRes=0, zero=1, err=0.
REQ-035 SHALL cover MUL with input1=0x0001_0003, input2=0x0000_0007 -> busy high for 32 cycles; done in cycle 33; aluRes=0x0007_0015, zero=0.
REQ-036 SHALL cover start with ADD 1+2 asserted mid-MUL -> ignored; one done pulse only, carrying the MUL result; the next ADD gives 3.
REQ-037 SHALL cover SRA with input1=0x8000_0000 and shift 31 -> 0xFFFF_FFFF; SLL with shift 32 (input2=32) -> 0, zero=1.
REQ-038 SHALL cover aluCtr=1111 -> done, aluRes=0, zero=1, err=1; a following ADD 0xFFFF_FFFF+1 -> aluRes=0, zero=1, err=0 (wrap-around).
REQ-039 SHALL cover rst_n pulled low at iteration 10 of a MUL -> outputs zero immediately, no done pulse; a new ADD is accepted on the first edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
//   - opcode encodings (OP_AND .. OP_MUL)
//   - FSM state encoding used by the top level
//   - is_legal_op(): true for every opcode the ALU implements
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StFin  = 2'd2
    } alu_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_SLL, OP_SRL, OP_SRA, OP_NOT, OP_MUL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (aborts a running multiply)
//   start       : latch op_a/op_b and begin; ignored while a multiply is running
//   op_a, op_b  : operands
//   done        : high during the final iteration cycle; result is valid then
//   result      : low WIDTH bits of op_a*op_b while done=1 (combinational)
// Iterations take place on the WIDTH edges following the start edge.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             last_iter;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = running_q && (cnt_q == CNT_W'(WIDTH - 1));

    // The final sum is handed out before it is registered so the top level
    // can capture it on the same edge as the last iteration.
    assign done   = last_iter;
    assign result = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
        end else if (!running_q) begin
            if (start) begin
                running_q <= 1'b1;
                cnt_q     <= '0;
                mcand_q   <= op_a;
                mplier_q  <= op_b;
                acc_q     <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (last_iter) begin
                running_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, iterative MUL.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request an operation; accepted only while busy=0
//   aluCtr         : opcode, sampled on acceptance
//   input1, input2 : operands, sampled on acceptance
//   busy           : high while a multiply iterates
//   done           : one-cycle pulse when aluRes/zero/err have been updated
//   aluRes         : registered result
//   zero           : registered, aluRes == 0
//   err            : registered, last operation had an illegal opcode
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluCtr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluRes,
    output logic             zero,
    output logic             err
);

    alu_state_e       state;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    logic [CNT_W-2:0] shamt;
    logic             shift_oob;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] alu_nxt;

    // busy is registered as state==StMul, so it doubles as the accept gate.
    assign accept    = start && !busy;
    assign mul_start = accept && (aluCtr == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .op_a   (input1),
        .op_b   (input2),
        .done   (mul_done),
        .result (mul_res)
    );

    // Single-cycle datapath.
    always_comb begin
        shamt     = input2[CNT_W-2:0];
        // Only reachable when WIDTH is not a power of two.
        shift_oob = {1'b0, shamt} >= CNT_W'(WIDTH);
        sra_res   = $signed(input1) >>> shamt;
        alu_nxt   = '0;
        case (aluCtr)
            OP_AND:  alu_nxt = input1 & input2;
            OP_OR:   alu_nxt = input1 | input2;
            OP_ADD:  alu_nxt = input1 + input2;
            OP_SUB:  alu_nxt = input1 - input2;
            OP_SLT:  alu_nxt = {{(WIDTH-1){1'b0}}, input1 < input2};
            OP_NOT:  alu_nxt = ~input1;
            OP_SLL:  alu_nxt = shift_oob ? '0 : (input1 << shamt);
            OP_SRL:  alu_nxt = shift_oob ? '0 : (input1 >> shamt);
            OP_SRA:  alu_nxt = shift_oob ? {WIDTH{input1[WIDTH-1]}} : sra_res;
            default: alu_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            aluRes <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StFin: begin
                    state <= StIdle;
                    if (accept) begin
                        if (aluCtr == OP_MUL) begin
                            state <= StMul;
                            busy  <= 1'b1;
                        end else begin
                            // Illegal opcodes fall through with alu_nxt = 0.
                            aluRes <= alu_nxt;
                            zero   <= (alu_nxt == '0);
                            err    <= !is_legal_op(aluCtr);
                            done   <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state  <= StFin;
                        busy   <= 1'b0;
                        aluRes <= mul_res;
                        zero   <= (mul_res == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32): the driver pushes the
// hand-computed response of each accepted operation, the monitor pops and
// compares on every done pulse.
module tb_multicycle_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  aluCtr;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] aluRes;
    logic        zero;
    logic        err;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [31:0] last_res;
    logic        last_zero;
    logic        last_err;

    multicycle_alu #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .aluCtr (aluCtr),
        .input1 (input1),
        .input2 (input2),
        .busy   (busy),
        .done   (done),
        .aluRes (aluRes),
        .zero   (zero),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: results on done, hold between pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res  = '0;
            last_zero = 1'b0;
            last_err  = 1'b0;
        end else if (done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done=1 res=%08h, required no pulse", aluRes);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (aluRes !== e.res || zero !== e.zero || err !== e.err) begin
                    fails++;
                    $display("FAIL result: got res=%08h zero=%b err=%b, required res=%08h zero=%b err=%b",
                             aluRes, zero, err, e.res, e.zero, e.err);
                end
            end
            last_res  = aluRes;
            last_zero = zero;
            last_err  = err;
        end else begin
            tests++;
            if (aluRes !== last_res || zero !== last_zero || err !== last_err) begin
                fails++;
                $display("FAIL hold: got res=%08h zero=%b err=%b, required res=%08h zero=%b err=%b",
                         aluRes, zero, err, last_res, last_zero, last_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic z, input logic e);
        exp_t x;
        x.res  = res;
        x.zero = z;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        aluCtr = op;
        input1 = a;
        input2 = b;
        @(negedge clk);
        start  = 1'b0;
        aluCtr = 4'b0000;
        input1 = '0;
        input2 = '0;
    endtask

    task automatic op1(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic z,
                       input logic e);
        push(res, z, e);
        drive(op, a, b);
        chk({name, "_latency"}, {31'd0, done}, 32'd1);
    endtask

    // Returns at the negedge where done should be high.
    task automatic wait_mul(input string name, input int exp_busy);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, n, exp_busy);
        chk({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic mul(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z);
        push(res, z, 1'b0);
        drive(OP_MUL, a, b);
        wait_mul(name, 32);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        aluCtr = '0;
        input1 = '0;
        input2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", aluRes, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Accepted on the first edge after release.
        rst_n = 1'b1;
        op1("add_first", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        op1("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
        op1("or", OP_OR, 32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF, 1'b0, 1'b0);
        op1("sub_eq", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        op1("sub_neg", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op1("slt_t", OP_SLT, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
        op1("slt_u", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        op1("not", OP_NOT, 32'h0F0F_0000, 32'd0, 32'hF0F0_FFFF, 1'b0, 1'b0);
        op1("sll", OP_SLL, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b0, 1'b0);
        op1("sll_4", OP_SLL, 32'd1, 32'd4, 32'h0000_0010, 1'b0, 1'b0);
        op1("sll_32", OP_SLL, 32'd0, 32'd32, 32'd0, 1'b1, 1'b0);
        op1("srl_31", OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0);
        op1("sra_31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op1("sra_pos", OP_SRA, 32'h4000_0000, 32'd30, 32'd1, 1'b0, 1'b0);
        op1("illegal", 4'b1111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1'b1);
        op1("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        op1("illegal2", 4'b0011, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1);

        // MUL, then back-to-back ops issued in each done cycle.
        mul("mul", 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, 1'b0);
        mul("mul_b2b", 32'd6, 32'd7, 32'd42, 1'b0);
        mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        mul("mul_zero", 32'd0, 32'd5, 32'd0, 1'b1);
        op1("add_after_mul", OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);

        // start mid-MUL is ignored.
        push(32'h0007_0015, 1'b0, 1'b0);
        drive(OP_MUL, 32'h0001_0003, 32'h0000_0007);
        repeat (4) @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd2);
        wait_mul("mul_ign", 27);
        op1("add_post_ign", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

        // Reset during iteration 10 aborts the multiply.
        push(32'h0007_0015, 1'b0, 1'b0);
        drive(OP_MUL, 32'h0001_0003, 32'h0000_0007);
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", aluRes, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_done_later", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        op1("add_post_rst", OP_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
